// File: rtl/dbus_arbiter.sv
// dbus_arbiter: two-master (m0 core, m1 debug/DMA with m1_lock bursts capped at LOCK_MAX) single-cycle data bus arbiter; mX_* requests in, mX_gnt/mX_rvalid/mX_rdata out, s_* slave strobe/mux out, s_rdata in
module dbus_arbiter #(
  parameter int LOCK_MAX = 8
) (
  input  logic        clk,
  input  logic        sync_rst_n,
  input  logic        clk_en,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [29:0] m0_addr,
  input  logic [3:0]  m0_mask,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [29:0] m1_addr,
  input  logic [3:0]  m1_mask,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        s_lock,
  output logic        s_we,
  output logic [29:0] s_addr,
  output logic [3:0]  s_mask,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata
);
  logic       last_gnt, prev_m1, rd_pend, rd_src;
  logic [7:0] lock_cnt;
  logic       act, lock_hold, sel1;
  assign act       = clk_en & sync_rst_n;
  assign lock_hold = prev_m1 & m1_lock & m1_req & (lock_cnt < 8'(LOCK_MAX));
  assign sel1      = lock_hold | (m1_req & (~m0_req | ~last_gnt));
  assign m1_gnt    = act & sel1;
  assign m0_gnt    = act & m0_req & ~sel1;
  assign s_lock    = m0_gnt | m1_gnt;
  assign s_we      = m1_gnt ? m1_we    : m0_gnt & m0_we;
  assign s_addr    = m1_gnt ? m1_addr  : m0_gnt ? m0_addr  : '0;
  assign s_mask    = m1_gnt ? m1_mask  : m0_gnt ? m0_mask  : '0;
  assign s_wdata   = m1_gnt ? m1_wdata : m0_gnt ? m0_wdata : '0;
  assign m0_rvalid = act & rd_pend & ~rd_src;
  assign m1_rvalid = act & rd_pend & rd_src;
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      last_gnt <= 1'b1;
      prev_m1  <= 1'b0;
      lock_cnt <= '0;
      rd_pend  <= 1'b0;
      rd_src   <= 1'b0;
    end else if (clk_en) begin
      if (s_lock) last_gnt <= m1_gnt;
      prev_m1  <= m1_gnt;
      lock_cnt <= (m1_gnt & m1_lock) ? lock_cnt + 8'(lock_hold) : '0;
      rd_pend  <= s_lock & ~s_we;
      rd_src   <= m1_gnt;
    end
  end
endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: scoreboard bench for dbus_arbiter against a cycle-level reference model
module tb_dbus_arbiter;
  localparam int LOCK_MAX = 8;
  logic        clk = 0;
  logic        sync_rst_n = 0, clk_en = 0;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [29:0] m0_addr = 0, m1_addr = 0;
  logic [3:0]  m0_mask = 0, m1_mask = 0;
  logic [31:0] m0_wdata = 0, m1_wdata = 0, s_rdata = 0;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, s_lock, s_we;
  logic [31:0] m0_rdata, m1_rdata, s_wdata;
  logic [29:0] s_addr;
  logic [3:0]  s_mask;

  dbus_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .sync_rst_n(sync_rst_n), .clk_en(clk_en),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_mask(m0_mask), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_mask(m1_mask), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .s_lock(s_lock), .s_we(s_we), .s_addr(s_addr),
    .s_mask(s_mask), .s_wdata(s_wdata), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rst_n, en, lock;
    logic r0, we0; logic [29:0] a0; logic [3:0] k0; logic [31:0] d0;
    logic r1, we1; logic [29:0] a1; logic [3:0] k1; logic [31:0] d1;
  } stim_t;

  typedef struct packed {
    logic g0, g1, sl, swe; logic [29:0] sa; logic [3:0] sm; logic [31:0] sw;
    logic v0, v1; logic [31:0] rd;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;

  // reference model state: who won last, whether m1 won the previous enabled cycle,
  // how many lock-forced grants in the current burst, and the outstanding read
  logic m_last = 1, m_prev1 = 0, m_pend = 0, m_src = 0;
  int   m_nlk = 0;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endfunction

  function automatic stim_t idle();
    stim_t s = '0;
    s.rst_n = 1;
    s.en = 1;
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e = '0;
    int   w = -1;
    bit   lk;
    @(posedge clk);
    #1;
    sync_rst_n = s.rst_n; clk_en = s.en; m1_lock = s.lock;
    m0_req = s.r0; m0_we = s.we0; m0_addr = s.a0; m0_mask = s.k0; m0_wdata = s.d0;
    m1_req = s.r1; m1_we = s.we1; m1_addr = s.a1; m1_mask = s.k1; m1_wdata = s.d1;
    s_rdata = $urandom;
    if (!s.rst_n) begin
      m_last = 1; m_prev1 = 0; m_nlk = 0; m_pend = 0; m_src = 0;
    end else if (s.en) begin
      e.v0 = m_pend && !m_src;
      e.v1 = m_pend && m_src;
      e.rd = s_rdata;
      lk = m_prev1 && s.lock && s.r1 && m_nlk < LOCK_MAX;
      if (lk) w = 1;
      else if (s.r0 && s.r1) w = m_last ? 0 : 1;
      else if (s.r0) w = 0;
      else if (s.r1) w = 1;
      if (w == 0) begin
        e.g0 = 1; e.sl = 1; e.swe = s.we0; e.sa = s.a0; e.sm = s.k0; e.sw = s.d0;
      end else if (w == 1) begin
        e.g1 = 1; e.sl = 1; e.swe = s.we1; e.sa = s.a1; e.sm = s.k1; e.sw = s.d1;
      end
      m_nlk   = (w == 1 && s.lock) ? m_nlk + (lk ? 1 : 0) : 0;
      m_prev1 = (w == 1);
      if (w >= 0) m_last = (w == 1);
      m_pend  = (w >= 0) && !e.swe;
      m_src   = (w == 1);
    end
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("m0_gnt", 32'(m0_gnt), 32'(e.g0));
      chk("m1_gnt", 32'(m1_gnt), 32'(e.g1));
      chk("s_lock", 32'(s_lock), 32'(e.sl));
      chk("s_we", 32'(s_we), 32'(e.swe));
      chk("s_addr", 32'(s_addr), 32'(e.sa));
      chk("s_mask", 32'(s_mask), 32'(e.sm));
      chk("s_wdata", s_wdata, e.sw);
      chk("m0_rvalid", 32'(m0_rvalid), 32'(e.v0));
      chk("m1_rvalid", 32'(m1_rvalid), 32'(e.v1));
      if (e.v0) chk("m0_rdata", m0_rdata, e.rd);
      if (e.v1) chk("m1_rdata", m1_rdata, e.rd);
    end
  end

  initial begin
    stim_t s;
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.rst_n = 0; s.en = 1'($urandom); s.r0 = 1; s.r1 = 1;
      step(s);
    end
    for (int i = 0; i < 12; i++) begin
      s = idle(); s.r0 = 1; s.r1 = 1; s.a0 = 30'(i); s.a1 = 30'(100 + i);
      step(s);
    end
    for (int i = 0; i < 24; i++) begin
      s = idle(); s.r0 = 1; s.r1 = 1; s.lock = 1; s.a0 = 30'(i); s.a1 = 30'(200 + i);
      step(s);
    end
    s = idle(); step(s);
    s = idle(); s.r0 = 1; s.we0 = 1; s.a0 = 30'h10; s.k0 = 4'b0101; s.d0 = 32'hAABBCCDD;
    step(s);
    s = idle(); step(s);
    s = idle(); s.r0 = 1; s.a0 = 30'h20; step(s);
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.en = 0; s.r0 = 1; s.r1 = 1; step(s);
    end
    s = idle(); step(s);
    s = idle(); step(s);
    s = idle(); s.r1 = 1; s.a1 = 30'h30; step(s);
    s = idle(); s.rst_n = 0; step(s);
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.r0 = 1; s.r1 = 1; step(s);
    end
    for (int i = 0; i < 3000; i++) begin
      s = '0;
      s.rst_n = ($urandom_range(63) != 0);
      s.en    = ($urandom_range(7) != 0);
      s.lock  = ($urandom_range(3) != 0);
      s.r0 = ($urandom_range(3) != 0); s.we0 = 1'($urandom); s.a0 = 30'($urandom);
      s.k0 = 4'($urandom); s.d0 = $urandom;
      s.r1 = ($urandom_range(3) != 0); s.we1 = 1'($urandom); s.a1 = 30'($urandom);
      s.k1 = 4'($urandom); s.d1 = $urandom;
      step(s);
    end
    for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left unchecked", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
